seg_scan_driver: RTL and testbench

- Upstream feeder for the per-digit seven-segment decoder: time-multiplexes a NUM_DIGITS-wide hex value onto one shared 4-bit nibble bus plus active-low digit enables.
- Accepts new display values through a valid/ready handshake into a one-entry pending buffer.
- Swaps the buffered value in only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Inserts anti-ghosting guard gaps between digits and optionally blanks leading zeros.

---
 rtl/seg_scan_driver.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a NUM_DIGITS-wide hex value onto a shared
// nibble bus with active-low digit enables. New values arrive through a
// one-entry pending buffer and are swapped in only at frame boundaries, so a
// frame never mixes old and new digits. Guard gaps keep all digits dark
// before each one is lit, and leading zeros can optionally be blanked.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      value_valid,
    output logic                      value_ready,
    input  logic                      blank_lz,
    output logic [3:0]                digit_data,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      frame_done
);

    localparam int DW  = 4 * NUM_DIGITS;
    localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TOT = GUARD_CYCLES + DWELL_CYCLES;
    localparam int CW  = (TOT > 1) ? $clog2(TOT) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SC_LAST   = CW'(TOT - 1);
    localparam logic [SW-1:0] SLOT_ZERO = {SW{1'b0}};
    localparam logic [CW-1:0] SC_ZERO   = {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Blank mask for a freshly loaded value: digit k>0 is blanked when it and
    // every more significant nibble are zero. Digit 0 always stays lit.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [DW-1:0] v,
        input logic          blz
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = {NUM_DIGITS{1'b0}};
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (v[4*k +: 4] == 4'h0);
            m[k]     = blz && all_zero && (k != 0);
        end
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [CW-1:0]           sc_q, sc_d;
    logic [DW-1:0]           disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    pend_full_q, pend_full_d;
    logic [DW-1:0]           pend_val_q, pend_val_d;
    logic [3:0]              digit_data_q, digit_data_d;
    logic [NUM_DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
    logic                    frame_done_q, frame_done_d;

    logic                    load_s;
    logic                    in_guard_s;
    logic [3:0]              nib_s;
    logic [NUM_DIGITS-1:0]   en_i_s;

    // With no guard time there is never a dark lead-in inside a slot.
    if (GUARD_CYCLES > 0) begin : g_guard
        assign in_guard_s = (sc_q < CW'(GUARD_CYCLES));
    end else begin : g_noguard
        assign in_guard_s = 1'b0;
    end

    // Select the display nibble and the undelayed enable pattern for the current slot.
    always_comb begin
        nib_s  = 4'h0;
        en_i_s = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slot_q == SW'(k)) begin
                nib_s     = disp_q[4*k +: 4];
                en_i_s[k] = ~((state_q == ST_SCAN) && !in_guard_s && !blank_q[k]);
            end else begin
                en_i_s[k] = 1'b1;
            end
        end
    end

    // Scan sequencing, frame-boundary load and pending-buffer handshake.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sc_d        = sc_q;
        disp_d      = disp_q;
        blank_d     = blank_q;
        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        load_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    load_s  = 1'b1;
                    state_d = ST_SCAN;
                    slot_d  = SLOT_ZERO;
                    sc_d    = SC_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (sc_q == SC_LAST) begin
                    sc_d = SC_ZERO;
                    if (slot_q == SLOT_LAST) begin
                        slot_d = SLOT_ZERO;
                        load_s = pend_full_q;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end else begin
                    sc_d = sc_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = SLOT_ZERO;
                sc_d    = SC_ZERO;
            end
        endcase

        // A load only happens while the buffer is full (ready low), so it can
        // never coincide with an accept.
        if (load_s) begin
            disp_d      = pend_val_q;
            blank_d     = lz_mask(pend_val_q, blank_lz);
            pend_full_d = 1'b0;
        end else if (value_valid && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_val_d  = value_in;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // Output register inputs: nibble latched at slot start, enables delayed one
    // clock to line up with the decoder's registered output, frame_done marking
    // the last cycle of the final slot.
    always_comb begin
        digit_data_d = digit_data_q;
        if ((state_q == ST_SCAN) && (sc_q == SC_ZERO)) begin
            digit_data_d = nib_s;
        end else begin
            digit_data_d = digit_data_q;
        end
        digit_en_n_d = en_i_s;
        frame_done_d = (state_d == ST_SCAN) && (slot_d == SLOT_LAST) && (sc_d == SC_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= SLOT_ZERO;
            sc_q         <= SC_ZERO;
            disp_q       <= {DW{1'b0}};
            blank_q      <= {NUM_DIGITS{1'b0}};
            pend_full_q  <= 1'b0;
            pend_val_q   <= {DW{1'b0}};
            digit_data_q <= 4'h0;
            digit_en_n_q <= {NUM_DIGITS{1'b1}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sc_q         <= sc_d;
            disp_q       <= disp_d;
            blank_q      <= blank_d;
            pend_full_q  <= pend_full_d;
            pend_val_q   <= pend_val_d;
            digit_data_q <= digit_data_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign value_ready = ~pend_full_q;
    assign digit_data  = digit_data_q;
    assign digit_en_n  = digit_en_n_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (N=4, DWELL=4, GUARD=1).
// A frame-position model predicts every output each cycle; directed
// literal checks pin the model to hand-computed values.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int G     = 1;
    localparam int TOT   = G + D;
    localparam int FRAME = N * TOT;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value_in;
    logic          value_valid;
    logic          value_ready;
    logic          blank_lz;
    logic [3:0]    digit_data;
    logic [3:0]    digit_en_n;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    seg_scan_driver #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GUARD_CYCLES(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
        .digit_data  (digit_data),
        .digit_en_n  (digit_en_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run  = 1'b0;
    int          m_pos  = 0;
    logic [15:0] m_disp = 16'h0;
    logic [3:0]  m_mask = 4'h0;
    bit          m_pf   = 1'b0;
    logic [15:0] m_pv   = 16'h0;
    logic [3:0]  exp_data  = 4'h0;
    logic [3:0]  exp_en    = 4'hF;
    logic        exp_ready = 1'b1;
    logic        exp_fd    = 1'b0;
    int          slot_v, sc_v;
    bit          acc_v;

    task automatic model_load();
        m_disp = m_pv;
        for (int k = 0; k < N; k++)
            m_mask[k] = (k > 0) && blank_lz && ((m_pv >> (4 * k)) == 16'h0);
        m_pf = 1'b0;
    endtask

    // Advance the model by one clock using the scan position within the frame.
    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_disp = 16'h0; m_mask = 4'h0;
            m_pf = 1'b0; m_pv = 16'h0;
            exp_data = 4'h0; exp_en = 4'hF; exp_ready = 1'b1; exp_fd = 1'b0;
        end else begin
            acc_v = value_valid && !m_pf;
            if (!m_run) begin
                exp_en = 4'hF;
                if (m_pf) begin
                    model_load();
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end else begin
                slot_v = m_pos / TOT;
                sc_v   = m_pos % TOT;
                exp_en = (sc_v < G || m_mask[slot_v]) ? 4'hF : ~(4'b0001 << slot_v);
                if (sc_v == 0) exp_data = 4'(m_disp >> (4 * slot_v));
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (m_pf) model_load();
                end else begin
                    m_pos++;
                end
            end
            if (acc_v) begin
                m_pf = 1'b1;
                m_pv = value_in;
            end
            exp_ready = !m_pf;
            exp_fd    = m_run && (m_pos == FRAME - 1);
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_digit_data", {28'h0, digit_data}, {28'h0, exp_data});
            chk("model_digit_en_n", {28'h0, digit_en_n}, {28'h0, exp_en});
            chk("model_value_ready", {31'h0, value_ready}, {31'h0, exp_ready});
            chk("model_frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
        end
    end

    task automatic wait_fd(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (value_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; value_in = 16'h0; value_valid = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        rst = 1'b0;

        // 1: idle after reset
        repeat (10) @(negedge clk);
        chk("idle_en", {28'h0, digit_en_n}, 32'hF);
        chk("idle_data", {28'h0, digit_data}, 32'h0);
        chk("idle_ready", {31'h0, value_ready}, 32'h1);

        // 2: 12A3, no blanking
        value_in = 16'h12A3; value_valid = 1'b1;
        @(negedge clk);                       // after accept edge
        value_valid = 1'b0;
        chk("t2_ready_low", {31'h0, value_ready}, 32'h0);
        @(negedge clk);                       // after load edge
        chk("t2_ready_back", {31'h0, value_ready}, 32'h1);
        @(negedge clk);
        chk("t2_data_slot0", {28'h0, digit_data}, 32'h3);
        @(negedge clk);
        chk("t2_en_slot0", {28'h0, digit_en_n}, 32'hE);
        repeat (4) @(negedge clk);
        chk("t2_data_slot1", {28'h0, digit_data}, 32'hA);
        @(negedge clk);
        chk("t2_en_slot1", {28'h0, digit_en_n}, 32'hD);
        repeat (11) @(negedge clk);
        chk("t2_fd_before", {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        chk("t2_fd_first", {31'h0, frame_done}, 32'h1);
        repeat (FRAME) @(negedge clk);
        chk("t2_fd_period", {31'h0, frame_done}, 32'h1);

        // 3: mid-frame 0050 with blanking
        repeat (7) @(negedge clk);
        blank_lz = 1'b1; value_in = 16'h0050; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("t3_ready_low", {31'h0, value_ready}, 32'h0);
        wait_fd("t3_wait_fd", 3 * FRAME);
        @(negedge clk);
        chk("t3_ready_after_load", {31'h0, value_ready}, 32'h1);
        chk("t3_old_digit3", {28'h0, digit_en_n}, 32'h7);
        @(negedge clk);
        chk("t3_new_data0", {28'h0, digit_data}, 32'h0);
        repeat (5) @(negedge clk);
        chk("t3_new_data1", {28'h0, digit_data}, 32'h5);
        @(negedge clk);
        chk("t3_en_digit1", {28'h0, digit_en_n}, 32'hD);
        repeat (5) @(negedge clk);
        chk("t3_digit2_dark", {28'h0, digit_en_n}, 32'hF);

        // 4: hold valid with a second value while pending is full
        blank_lz = 1'b0; value_in = 16'h0900; value_valid = 1'b1;
        @(negedge clk);
        value_in = 16'h0007;
        chk("t4_ready_low", {31'h0, value_ready}, 32'h0);
        wait_ready("t4_wait_ready", 3 * FRAME);
        @(negedge clk);
        value_valid = 1'b0;
        chk("t4_captured", {31'h0, value_ready}, 32'h0);
        wait_fd("t4_wait_fd", 3 * FRAME);
        repeat (2) @(negedge clk);
        chk("t4_second_value", {28'h0, digit_data}, 32'h7);

        // 5: zero with blanking shows a single 0
        blank_lz = 1'b1; value_in = 16'h0000; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_fd("t5_wait_fd", 3 * FRAME);
        repeat (2) @(negedge clk);
        chk("t5_data0", {28'h0, digit_data}, 32'h0);
        @(negedge clk);
        chk("t5_en_digit0", {28'h0, digit_en_n}, 32'hE);
        repeat (5) @(negedge clk);
        chk("t5_digit1_dark", {28'h0, digit_en_n}, 32'hF);

        // 6: reset in slot 2 with a value pending
        wait_fd("t6_wait_fd", 3 * FRAME);
        repeat (13) @(negedge clk);
        value_in = 16'h4444; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_en", {28'h0, digit_en_n}, 32'hF);
        chk("t6_rst_data", {28'h0, digit_data}, 32'h0);
        chk("t6_rst_ready", {31'h0, value_ready}, 32'h1);
        chk("t6_rst_fd", {31'h0, frame_done}, 32'h0);
        repeat (30) @(negedge clk);
        chk("t6_stays_dark", {28'h0, digit_en_n}, 32'hF);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
